// File: rtl/imem_fetch_responder_pkg.sv
// ============================================================================
// Module      : imem_fetch_responder_pkg
// Description : Shared types, constants and FSM encoding for the fetch responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_responder_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  // addi x0,x0,0
  localparam data_t IMEM_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_responder_line_buf.sv
// ============================================================================
// Module      : imem_line_buf
// Description : One instruction entry (valid/tag/data) with word-tag compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_line_buf
  import imem_fetch_responder_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inv_i,
  input  logic  fill_i,
  input  addr_t fill_addr_i,
  input  data_t fill_data_i,
  input  addr_t cmp_addr_i,
  output logic  valid_o,
  output addr_t addr_o,
  output data_t data_o,
  output logic  match_o
);

  logic  valid_q;
  addr_t addr_q;
  data_t data_q;
  logic  w_unused_lsb;

  // Invalidate wins over a simultaneous fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end
  end

  assign valid_o      = valid_q;
  assign addr_o       = addr_q;
  assign data_o       = data_q;
  assign match_o      = valid_q && (addr_q[31:2] == cmp_addr_i[31:2]);
  assign w_unused_lsb = ^cmp_addr_i[1:0];

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// ============================================================================
// Module      : imem_fetch_responder
// Description : Fetch-side instruction responder with line buffer and a
//               single outstanding req/ack bus read. Optional next-line
//               prefetch entry enabled by defining IMEM_PREFETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter data_t       NOP_INSTR      = IMEM_NOP_INSTR,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic    clk,
  input  logic    rst,
  input  addr_t   pc_i,
  input  logic    fence_i,
  output data_t   instruction_o,
  output enable_t stall_c_o,
  output logic    mem_req_o,
  output addr_t   mem_addr_o,
  input  logic    mem_ack_i,
  input  data_t   mem_rdata_i,
  output logic    err_o
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TMO = CNT_W'(TIMEOUT_CYCLES);

  imem_state_e      state_q, state_d;
  addr_t            req_addr_q, req_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  addr_t w_pc_al;
  logic  w_req, w_xfer, w_hit, w_buf_hit;
  addr_t w_addr;
  logic  w_buf_fill, w_buf_inv;
  addr_t w_buf_fill_addr;
  data_t w_buf_fill_data;
  logic  w_buf_valid, w_buf_match;
  addr_t w_buf_addr;
  data_t w_buf_data;

  assign w_pc_al   = {pc_i[31:2], 2'b00};
  assign w_buf_hit = w_buf_match && !fence_i;
  // Reset forces the bus idle immediately, even between edges.
  assign mem_req_o  = w_req && !rst;
  assign mem_addr_o = w_addr;
  assign w_xfer     = mem_req_o && mem_ack_i;
  assign err_o      = err_q;

  imem_line_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .inv_i       (w_buf_inv),
    .fill_i      (w_buf_fill),
    .fill_addr_i (w_buf_fill_addr),
    .fill_data_i (w_buf_fill_data),
    .cmp_addr_i  (pc_i),
    .valid_o     (w_buf_valid),
    .addr_o      (w_buf_addr),
    .data_o      (w_buf_data),
    .match_o     (w_buf_match)
  );

`ifdef IMEM_PREFETCH_EN
  logic  pf_tag_q, pf_tag_d;
  logic  w_pf_fill, w_pf_inv, w_pf_valid, w_pf_match, w_pf_hit, w_promote, w_pf_needed;
  addr_t w_pf_addr, w_next;
  data_t w_pf_data;

  imem_line_buf u_pf (
    .clk         (clk),
    .rst         (rst),
    .inv_i       (w_pf_inv),
    .fill_i      (w_pf_fill),
    .fill_addr_i (req_addr_q),
    .fill_data_i (mem_rdata_i),
    .cmp_addr_i  (pc_i),
    .valid_o     (w_pf_valid),
    .addr_o      (w_pf_addr),
    .data_o      (w_pf_data),
    .match_o     (w_pf_match)
  );

  assign w_pf_hit      = w_pf_match && !fence_i;
  assign w_hit         = w_buf_hit || w_pf_hit;
  assign w_next        = w_buf_addr + 32'd4;
  assign w_pf_needed   = w_buf_valid && (!w_pf_valid || (w_pf_addr[31:2] != w_next[31:2]));
  // A promoted entry leaves pf unless a prefetch fill lands on the same edge.
  assign w_pf_inv      = fence_i || (w_promote && !w_pf_fill);
  assign instruction_o = w_buf_hit ? w_buf_data : (w_pf_hit ? w_pf_data : NOP_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pf_tag_q <= 1'b0;
    else     pf_tag_q <= pf_tag_d;
  end
`else
  logic w_unused_buf;

  assign w_hit         = w_buf_hit;
  assign w_unused_buf  = w_buf_valid ^ (^w_buf_addr);
  assign instruction_o = w_buf_hit ? w_buf_data : NOP_INSTR;
`endif

  assign stall_c_o = !w_hit;
  assign w_buf_inv = fence_i;

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    w_req           = 1'b0;
    w_addr          = req_addr_q;
    w_buf_fill      = 1'b0;
    w_buf_fill_addr = w_pc_al;
    w_buf_fill_data = mem_rdata_i;
`ifdef IMEM_PREFETCH_EN
    pf_tag_d        = pf_tag_q;
    w_pf_fill       = 1'b0;
    w_promote       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fence_i && !w_hit) begin
          w_req      = 1'b1;
          w_addr     = w_pc_al;
          req_addr_d = w_pc_al;
`ifdef IMEM_PREFETCH_EN
          pf_tag_d   = 1'b0;
`endif
          if (mem_ack_i) w_buf_fill = 1'b1;
          else           state_d    = WAIT;
        end
`ifdef IMEM_PREFETCH_EN
        else if (!fence_i && w_buf_hit && w_pf_needed) begin
          w_req      = 1'b1;
          w_addr     = w_next;
          req_addr_d = w_next;
          pf_tag_d   = 1'b1;
          if (mem_ack_i) w_pf_fill = 1'b1;
          else           state_d   = WAIT;
        end
`endif
      end
      WAIT: begin
        w_req = 1'b1;
        if (fence_i) begin
          state_d = mem_ack_i ? IDLE : DRAIN;
        end else if (mem_ack_i) begin
          state_d = IDLE;
`ifdef IMEM_PREFETCH_EN
          if (pf_tag_q) w_pf_fill = 1'b1;
          else
`endif
          if (req_addr_q[31:2] == pc_i[31:2]) begin
            w_buf_fill      = 1'b1;
            w_buf_fill_addr = req_addr_q;
          end
        end
      end
      DRAIN: begin
        w_req = 1'b1;
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef IMEM_PREFETCH_EN
    if (w_pf_hit && !w_buf_hit && !w_buf_fill) begin
      w_promote       = 1'b1;
      w_buf_fill      = 1'b1;
      w_buf_fill_addr = w_pf_addr;
      w_buf_fill_data = w_pf_data;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_xfer)
      cnt_d = '0;
    else if ((state_q == WAIT || state_q == DRAIN) && cnt_q != C_TMO)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      if (cnt_d == C_TMO) err_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// ============================================================================
// Module      : tb_imem_fetch_responder
// Description : Directed self-checking bench for imem_fetch_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        fence_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] instruction_o;
  logic        stall_c_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  imem_fetch_responder dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .fence_i       (fence_i),
    .instruction_o (instruction_o),
    .stall_c_o     (stall_c_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #2;
    check("rst_stall", 32'(stall_c_o), 32'd1);
    check("rst_instr", instruction_o, NOP);
    check("rst_req",   32'(mem_req_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();

`ifdef IMEM_PREFETCH_EN
    pc_i = 32'h10; mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    settle();
    check("pf_dem_addr", mem_addr_o, 32'h10);
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("pf_hit_stall", 32'(stall_c_o), 32'd0);
    check("pf_hit_instr", instruction_o, 32'hAAAA_0001);
    check("pf_req",       32'(mem_req_o), 32'd1);
    check("pf_addr",      mem_addr_o, 32'h14);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_0002;
    settle();
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h14;
    settle();
    check("pf_next_stall", 32'(stall_c_o), 32'd0);
    check("pf_next_instr", instruction_o, 32'hAAAA_0002);
`else
    // 1: miss at 0x0, ack three cycles after the request
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0050_0093;
      end
      settle();
      check($sformatf("t1_stall_%0d", i), 32'(stall_c_o), 32'd1);
      check($sformatf("t1_addr_%0d", i),  mem_addr_o, 32'h0);
      check($sformatf("t1_req_%0d", i),   32'(mem_req_o), 32'd1);
      tick();
      mem_ack_i = 1'b0;
    end
    settle();
    check("t1_instr", instruction_o, 32'h0050_0093);
    check("t1_stall", 32'(stall_c_o), 32'd0);

    // 2: sustained hit
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_stall_%0d", i), 32'(stall_c_o), 32'd0);
      check($sformatf("t2_req_%0d", i),   32'(mem_req_o), 32'd0);
      tick();
    end

    // 3: fence in WAIT drains the outstanding read
    pc_i = 32'h4;
    settle();
    check("t3_addr", mem_addr_o, 32'h4);
    tick();
    fence_i = 1'b1;
    settle();
    check("t3_fence_stall", 32'(stall_c_o), 32'd1);
    tick();
    fence_i = 1'b0;
    settle();
    check("t3_drain_req",  32'(mem_req_o), 32'd1);
    check("t3_drain_addr", mem_addr_o, 32'h4);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("t3_discard_instr", instruction_o, NOP);
    check("t3_discard_stall", 32'(stall_c_o), 32'd1);
    check("t3_rereq",         32'(mem_req_o), 32'd1);
    check("t3_rereq_addr",    mem_addr_o, 32'h4);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("t3_refill", instruction_o, 32'h1111_1111);

    // 4: pc moves away before the ack
    pc_i = 32'h8;
    settle();
    check("t4_addr8", mem_addr_o, 32'h8);
    tick();
    pc_i = 32'hC;
    settle();
    check("t4_addr_held", mem_addr_o, 32'h8);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h2222_2222;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("t4_discard", instruction_o, NOP);
    check("t4_req",     32'(mem_req_o), 32'd1);
    check("t4_addrC",   mem_addr_o, 32'hC);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_3333;
    tick();
    mem_ack_i = 1'b0;
    settle();
    check("t4_fillC", instruction_o, 32'h3333_3333);

    // 5: no ack -> sticky timeout at 256 WAIT cycles
    pc_i = 32'h40;
    settle();
    tick();
    repeat (255) tick();
    check("t5_err_255", 32'(err_o), 32'd0);
    check("t5_req_255", 32'(mem_req_o), 32'd1);
    tick();
    check("t5_err_256", 32'(err_o), 32'd1);
    repeat (3) tick();
    check("t5_err_sticky", 32'(err_o), 32'd1);
    check("t5_req_held",   32'(mem_req_o), 32'd1);
    check("t5_addr_held",  mem_addr_o, 32'h40);

    // 6: reset mid-WAIT, late ack must not fill
    rst = 1'b1;
    settle();
    check("t6_req",   32'(mem_req_o), 32'd0);
    check("t6_stall", 32'(stall_c_o), 32'd1);
    check("t6_err",   32'(err_o), 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h4444_4444;
    tick();
    mem_ack_i = 1'b0;
    rst = 1'b0;
    settle();
    check("t6_late_stall", 32'(stall_c_o), 32'd1);
    check("t6_late_instr", instruction_o, NOP);
    check("t6_new_addr",   mem_addr_o, 32'h40);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
